// File: rtl/fxp_div_pkg.sv
// Shared types and helpers for the sequential fixed-point divider family.
package fxp_div_pkg;

    // Controller states of the divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } fxp_state_e;

    // Widest word the limit helpers can describe.
    localparam int FXP_MAXW = 128;

    // Default Q17.15 configuration of the pseudoinverse datapath.
    localparam int FXP_DEF_W = 32;
    localparam int FXP_DEF_F = 15;

    // Quotient bits produced per operation in the default configuration.
    localparam int ITER = FXP_DEF_W + FXP_DEF_F;

    // Quotient bits (one per CALC cycle) for a given format.
    function automatic int fxp_iter(input int w, input int f);
        return w + f;
    endfunction

    // Largest representable value, as a zero-extended bit pattern.
    function automatic logic [FXP_MAXW-1:0] fxp_max(input int w, input bit signed_mode);
        logic [FXP_MAXW-1:0] r;
        int                  ones;
        r    = '0;
        ones = signed_mode ? w - 1 : w;
        for (int i = 0; i < FXP_MAXW; i++) begin
            if (i < ones) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Smallest representable value, as a W-bit two's-complement pattern
    // zero-extended (its magnitude is also 2^(W-1) when signed).
    function automatic logic [FXP_MAXW-1:0] fxp_min(input int w, input bit signed_mode);
        logic [FXP_MAXW-1:0] r;
        r = '0;
        if (signed_mode) r[w-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fxp_div_sat.sv
// Sign application, saturation and flag generation for a fixed-point
// quotient magnitude. Purely combinational.
module fxp_div_sat
    import fxp_div_pkg::*;
#(
    parameter int W      = 32,
    parameter int F      = 15,
    parameter int SIGNED = 1
) (
    input  logic [W+F-1:0] mag_i,    // truncated quotient magnitude
    input  logic           neg_i,    // result sign (operand signs differ)
    input  logic           a_neg_i,  // dividend sign, picks the zero-divide limit
    input  logic           dz_i,     // divisor was zero
    output logic [W-1:0]   res_o,
    output logic           ovf_o,
    output logic           dz_o
);

    localparam logic [FXP_MAXW-1:0] MAX_WIDE = fxp_max(W, SIGNED != 0);
    localparam logic [FXP_MAXW-1:0] MIN_WIDE = fxp_min(W, SIGNED != 0);
    localparam logic [W-1:0]        MAX_RES  = MAX_WIDE[W-1:0];
    localparam logic [W-1:0]        MIN_RES  = MIN_WIDE[W-1:0];
    // Magnitude limits compared against the wide quotient.
    localparam logic [W+F-1:0]      POS_LIM  = MAX_WIDE[W+F-1:0];
    localparam logic [W+F-1:0]      NEG_LIM  = MIN_WIDE[W+F-1:0];

    // Pick the saturated limit or the signed quotient and raise the flags.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        res_o = '0;
        ovf_o = 1'b0;
        dz_o  = dz_i;
        if (dz_i) begin
            res_o = (SIGNED != 0 && a_neg_i) ? MIN_RES : MAX_RES;
        end else if (SIGNED != 0 && neg_i) begin
            if (mag_i > NEG_LIM) begin
                res_o = MIN_RES;
                ovf_o = 1'b1;
            end else begin
                res_o = -mag_i[W-1:0];
            end
        end else begin
            if (mag_i > POS_LIM) begin
                res_o = MAX_RES;
                ovf_o = 1'b1;
            end else begin
                res_o = mag_i[W-1:0];
            end
        end
    end

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential radix-2 restoring fixed-point divider, one quotient bit per
// clock, with start/busy/done handshake and saturating result.
module fxp_div_seq
    import fxp_div_pkg::*;
#(
    parameter int W      = FXP_DEF_W,
    parameter int F      = FXP_DEF_F,
    parameter int SIGNED = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int             N        = fxp_iter(W, F);
    localparam int             CW       = $clog2(N + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(N - 1);

    fxp_state_e     state_q, state_d;

    logic [N-1:0]   dvd_q;      // remaining dividend bits, MSB first
    logic [N-1:0]   quo_q;      // quotient magnitude being assembled
    logic [W-1:0]   rem_q;      // partial remainder, always below |b|
    logic [W-1:0]   bmag_q;     // divisor magnitude
    logic [CW-1:0]  cnt_q;      // iterations left minus one
    logic           neg_q;
    logic           a_neg_q;
    logic           dz_q;
    logic [W-1:0]   res_q;
    logic           ovf_q;
    logic           dzf_q;

    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     rem_sh;
    logic           q_bit;
    logic [W-1:0]   sat_res;
    logic           sat_ovf, sat_dz;

    // Operand signs and magnitudes; -(-2^(W-1)) is still correct as unsigned.
    always_comb begin
        a_neg = (SIGNED != 0) && a[W-1];
        b_neg = (SIGNED != 0) && b[W-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        rem_sh = {rem_q, dvd_q[N-1]};
        q_bit  = (rem_sh >= {1'b0, bmag_q});
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is only ever written with non-blocking assignments.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (b == '0) ? FIX : CALC;
            CALC: if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        busy = (state_q == CALC) || (state_q == FIX);
        done = (state_q == DONE);
    end

    // Iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath is small and reset is required to clear it, so it
        // shares the async reset; no storage here is RAM-mapped.
        if (!rst_n) begin
            dvd_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            bmag_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            dzf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q   <= N'(a_mag) << F;
                        quo_q   <= '0;
                        rem_q   <= '0;
                        bmag_q  <= b_mag;
                        cnt_q   <= CNT_LOAD;
                        neg_q   <= a_neg ^ b_neg;
                        a_neg_q <= a_neg;
                        dz_q    <= (b == '0);
                    end
                end
                CALC: begin
                    rem_q <= q_bit ? W'(rem_sh - {1'b0, bmag_q}) : rem_sh[W-1:0];
                    dvd_q <= dvd_q << 1;
                    quo_q <= (quo_q << 1) | N'(q_bit);
                    cnt_q <= cnt_q - 1'b1;
                end
                FIX: begin
                    res_q <= sat_res;
                    ovf_q <= sat_ovf;
                    dzf_q <= sat_dz;
                end
                default: ;
            endcase
        end
    end

    fxp_div_sat #(
        .W      (W),
        .F      (F),
        .SIGNED (SIGNED)
    ) u_sat (
        .mag_i   (quo_q),
        .neg_i   (neg_q),
        .a_neg_i (a_neg_q),
        .dz_i    (dz_q),
        .res_o   (sat_res),
        .ovf_o   (sat_ovf),
        .dz_o    (sat_dz)
    );

    assign res         = res_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dzf_q;

endmodule

// File: tb/tb_fxp_div_seq.sv
// Scoreboard bench for fxp_div_seq: a Q17.15 signed instance and an 8-bit
// unsigned integer instance, both checked against an arithmetic model.
module tb_fxp_div_seq;
    import fxp_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start8;
    logic [31:0] a0, b0, res0;
    logic [7:0]  a8, b8, res8;
    logic        busy0, done0, dz0, ovf0;
    logic        busy8, done8, dz8, ovf8;

    always #5 clk = ~clk;

    fxp_div_seq #(.W(32), .F(15), .SIGNED(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .res(res0), .div_by_zero(dz0), .overflow(ovf0)
    );

    fxp_div_seq #(.W(8), .F(0), .SIGNED(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .res(res8), .div_by_zero(dz8), .overflow(ovf8)
    );

    typedef struct {
        logic [31:0] res;
        logic        dz;
        logic        ovf;
        int          due;   // posedge count at which done must be visible
    } exp_t;

    exp_t q0[$], q8[$];
    exp_t last0, last8;
    int   pe;               // posedges seen so far
    int   n_vec, n_bad;

    always @(posedge clk) pe <= pe + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: real quotient a*2^f/b truncated toward zero, then clamped.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b,
                                     input int w, input int f, input bit sgn);
        exp_t   e;
        longint av, bv, mx, mn, q;
        logic [31:0] mask;
        av   = sgn ? longint'($signed(a)) : longint'(a);
        bv   = sgn ? longint'($signed(b)) : longint'(b);
        mx   = sgn ? (64'sd1 <<< (w - 1)) - 1 : (64'sd1 <<< w) - 1;
        mn   = sgn ? -(64'sd1 <<< (w - 1)) : 64'sd0;
        mask = (w == 32) ? 32'hFFFF_FFFF : (32'h1 << w) - 32'h1;
        e.dz  = (bv == 0);
        e.ovf = 1'b0;
        if (bv == 0) begin
            q = (av < 0) ? mn : mx;
        end else begin
            q = (av * (64'sd1 <<< f)) / bv;
            if (q > mx) begin
                q = mx;
                e.ovf = 1'b1;
            end else if (q < mn) begin
                q = mn;
                e.ovf = 1'b1;
            end
        end
        e.res = 32'(q) & mask;
        e.due = 0;
        return e;
    endfunction

    function automatic int latency(input bit w8, input bit dz);
        if (dz) return 2;
        return w8 ? 8 + 0 + 2 : ITER + 2;
    endfunction

    // Monitor for the Q17.15 instance.
    always @(negedge clk) begin
        bit ed;
        ed = 1'b0;
        if (q0.size() > 0) ed = (pe == q0[0].due);
        check("d0_done", {31'b0, done0}, {31'b0, ed});
        check("d0_busy", {31'b0, busy0}, {31'b0, (q0.size() > 0) && !ed});
        if (ed) begin
            last0 = q0.pop_front();
            n_vec++;
        end
        check("d0_res", res0, last0.res);
        check("d0_dz",  {31'b0, dz0},  {31'b0, last0.dz});
        check("d0_ovf", {31'b0, ovf0}, {31'b0, last0.ovf});
    end

    // Monitor for the 8-bit unsigned instance.
    always @(negedge clk) begin
        bit ed;
        ed = 1'b0;
        if (q8.size() > 0) ed = (pe == q8[0].due);
        check("d8_done", {31'b0, done8}, {31'b0, ed});
        check("d8_busy", {31'b0, busy8}, {31'b0, (q8.size() > 0) && !ed});
        if (ed) begin
            last8 = q8.pop_front();
            n_vec++;
        end
        check("d8_res", {24'b0, res8}, last8.res);
        check("d8_dz",  {31'b0, dz8},  {31'b0, last8.dz});
        check("d8_ovf", {31'b0, ovf8}, {31'b0, last8.ovf});
    end

    task automatic wait_idle(input bit w8);
        for (int i = 0; i < 200; i++) begin
            if ((w8 ? q8.size() : q0.size()) == 0) break;
            @(negedge clk);
        end
        if ((w8 ? q8.size() : q0.size()) != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: done never arrived, %0d outstanding", w8 ? "d8" : "d0",
                     w8 ? q8.size() : q0.size());
            if (w8) q8.delete(); else q0.delete();
        end
    endtask

    // Present one operation, record its expectation at the accepting edge.
    task automatic push_op(input bit w8, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
            e = ref_div({24'b0, a[7:0]}, {24'b0, b[7:0]}, 8, 0, 1'b0);
        end else begin
            a0 = a; b0 = b; start0 = 1'b1;
            e = ref_div(a, b, 32, 15, 1'b1);
        end
        @(posedge clk);
        e.due = pe + latency(w8, e.dz);
        if (w8) q8.push_back(e); else q0.push_back(e);
        @(negedge clk);
        start0 = 1'b0;
        start8 = 1'b0;
        a0 = $urandom;
        b0 = $urandom;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b);
        push_op(w8, a, b);
        wait_idle(w8);
    endtask

    task automatic clear_expect();
        q0.delete();
        q8.delete();
        last0.res = '0; last0.dz = 1'b0; last0.ovf = 1'b0; last0.due = 0;
        last8.res = '0; last8.dz = 1'b0; last8.ovf = 1'b0; last8.due = 0;
    endtask

    // Watchdog: the stimulus below is a few thousand cycles.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        exp_t        e;
        rst_n  = 1'b0;
        start0 = 1'b0; start8 = 1'b0;
        a0 = '0; b0 = '0; a8 = '0; b8 = '0;
        n_vec = 0; n_bad = 0;
        clear_expect();
        repeat (3) @(negedge clk);
        check("rst_res",  res0, 32'h0);
        check("rst_busy", {31'b0, busy0}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases from the Q17.15 plan.
        run_op(1'b0, 32'h0002_8000, 32'h0001_0000);   //  5.0 / 2.0
        run_op(1'b0, 32'hFFFD_8000, 32'h0001_0000);   // -5.0 / 2.0
        run_op(1'b0, 32'h0000_8000, 32'h0000_0000);   //  1.0 / 0
        run_op(1'b0, 32'hFFFF_8000, 32'h0000_0000);   // -1.0 / 0
        run_op(1'b0, 32'h7FFF_8000, 32'h0000_4000);   // 65535 / 0.5
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_8000);   // min / -1.0
        run_op(1'b0, 32'h8000_0000, 32'h0000_8000);   // min / 1.0, exact
        run_op(1'b0, 32'h0000_0000, 32'h0000_0000);   // 0 / 0

        // Start held high: ignored while busy, re-accepted right after DONE.
        @(negedge clk);
        a0 = 32'h0001_8000; b0 = 32'hFFFF_4000; start0 = 1'b1;   // 3.0 / -1.5
        e = ref_div(a0, b0, 32, 15, 1'b1);
        @(posedge clk);
        e.due = pe + latency(1'b0, e.dz);
        q0.push_back(e);
        repeat (ITER + 3) @(posedge clk);
        e.due = pe + latency(1'b0, e.dz);
        q0.push_back(e);
        @(negedge clk); start0 = 1'b0;
        wait_idle(1'b0);

        // Reset mid-operation: the second start is ignored and no done appears.
        push_op(1'b0, 32'h0002_8000, 32'h0001_0000);
        repeat (9) @(negedge clk);
        a0 = 32'h0000_8000; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        clear_expect();
        @(negedge clk);
        check("mid_rst_res",  res0, 32'h0);
        check("mid_rst_done", {31'b0, done0}, 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (60) @(negedge clk);                     // old op must stay dead
        run_op(1'b0, 32'h0000_8000, 32'h0000_8000);   // 1.0 / 1.0

        // 8-bit unsigned integer instance.
        run_op(1'b1, 32'd200, 32'd7);
        run_op(1'b1, 32'd200, 32'd0);
        run_op(1'b1, 32'd255, 32'd1);
        run_op(1'b1, 32'd3,   32'd255);

        // Randomised Q17.15 traffic over a spread of magnitudes and signs.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom >> $urandom_range(0, 24);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 7) == 0) begin
                rb = 32'h0;
            end else begin
                rb = $urandom >> $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            run_op(1'b0, ra, rb);
        end

        // Randomised unsigned traffic.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom_range(0, 255);
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom_range(1, 255);
            run_op(1'b1, ra, rb);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fxp_div_seq.md
Name: fxp_div_seq

Overview:
- Parametrised sequential fixed-point divider; successor to the fixed 32-bit Q17.15 Division unit used by the pseudoinverse datapath.
- Generalised in word width, fractional bits and signedness.
- Adds a start/busy/done handshake, divide-by-zero and overflow flags, saturation and an active-low asynchronous reset.
- Radix-2 restoring iteration, one quotient bit per clock. Sits between the matrix-element scheduler and the pseudoinverse result buffers.

Parameters:
- W, 32, total word width of a, b and res (two's complement when SIGNED=1).
- F, 15, fractional bits; Q(W-F).F format; requires 0 <= F < W.
- SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  W  dividend; captured on the accepted start.
- b  input  W  divisor; captured on the accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse; res and flags are valid in this cycle.
- res  output  W  quotient (a/b) in the same Q format; held until the next done.
- div_by_zero  output  1  b was 0 for the last completed operation; held with res.
- overflow  output  1  true quotient was not representable and res was saturated; held with res.

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, res=0, div_by_zero=0, overflow=0; internal registers cleared.
- Reset mid-operation aborts the operation with no done pulse. After release, the block is in IDLE and accepts a new start.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 captures a and b, computes magnitudes (SIGNED) and the result sign, and loads the W+F-bit dividend |a|<<F.
  - b==0 -> go to FIX directly with a zero-divide marker.
  - Otherwise -> CALC with the iteration counter set to W+F-1.
- CALC:
  - Each cycle: shift the partial remainder left, bring in the next dividend MSB, trial-subtract |b|.
  - A non-negative difference sets the quotient bit to 1 and keeps the difference; otherwise the quotient bit is 0 and the remainder is restored.
  - Exactly W+F cycles, then FIX.
- FIX (1 cycle): apply sign, then saturate.
  - SIGNED: positive limit 2^(W-1)-1; negative limit -2^(W-1).
  - Unsigned: limit 2^W-1.
  - Magnitude above the limit -> res = limit of the result sign, overflow=1.
  - Zero-divide -> res = positive limit if a>=0, negative limit if a<0 (unsigned: all ones); div_by_zero=1, overflow=0.
  - Rounding: truncation toward zero on the magnitude.
- DONE (1 cycle): done=1, busy=0, res and flags updated, next state IDLE.
- Latency:
  - Normal: done asserts W+F+2 cycles after the edge that accepts start (49 for defaults).
  - Zero-divide: done asserts 2 cycles after that edge.
- start while busy or in DONE is ignored, not queued. start held high re-triggers in the first IDLE cycle after DONE.
- a and b may change freely after acceptance.
- The special case -2^(W-1) / -1.0 must produce positive saturation with overflow=1.

Decomposition:
- Package fxp_div_pkg:
  - state enum (IDLE, CALC, FIX, DONE).
  - functions fxp_max(W,SIGNED) and fxp_min(W,SIGNED) for saturation limits.
  - localparam ITER = W+F.
- One natural sub-module, fxp_div_sat: combinational sign-apply plus saturation plus flag generation, used in FIX and reusable by the multiplier block.
- The iteration datapath stays in fxp_div_seq.

Test Plan (defaults W=32, F=15, SIGNED=1):
- a=0x00028000 (5.0), b=0x00010000 (2.0), start pulse -> done at cycle 49 with res=0x00014000 (2.5), div_by_zero=0, overflow=0; busy high cycles 1..48.
- a=0xFFFD8000 (-5.0), b=0x00010000 -> res=0xFFFEC000 (-2.5), flags 0.
- a=0x00008000 (1.0), b=0 -> done at cycle 2, res=0x7FFFFFFF, div_by_zero=1; repeat with a=0xFFFF8000 -> res=0x80000000.
- a=0x7FFF8000 (65535.0), b=0x00004000 (0.5) -> res=0x7FFFFFFF, overflow=1; then a=0x80000000, b=0xFFFF8000 (-1.0) -> res=0x7FFFFFFF, overflow=1.
- Start 5.0/2.0, pulse start again at cycle 10 with a=0x00008000, then drop rst_n at cycle 20 -> the second start is ignored; after reset all outputs are 0 and no done pulse occurs. A fresh 1.0/0x00008000 start yields res=0x00008000.
- F=0, W=8, SIGNED=0 instance: a=200, b=7 -> res=28, done at cycle 10; b=0 -> res=0xFF, div_by_zero=1.
